fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 46 ++++
 rtl/fifo_wr_arbiter_if.sv | 34 +++
 rtl/fifo_wr_arbiter_rr_pick_onehot.sv | 57 +++++
 rtl/fifo_wr_arbiter.sv | 102 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types, default constants and a round-robin search
//                helper for the async_fifo write-side arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Default sizing for the arbiter and its interface.
    localparam int c_def_num_req    = 4;
    localparam int c_def_data_width = 8;
    localparam int c_def_burst_len  = 4;

    // Arbiter FSM states, explicit 1-bit encoding.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Result of a round-robin search: found flag plus winning index.
    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Behavioural round-robin search over up to 16 requesters, starting one
    // past 'last' and wrapping modulo num_req.
    function automatic pick_t rr_pick(input logic [15:0] req_vec,
                                      input logic [3:0]  last,
                                      input int          num_req);
        pick_t res;
        int    k;
        res = '0;
        for (int i = 1; i <= 16; i++) begin
            k = (int'(last) + i) % num_req;
            if (i <= num_req && !res.found && req_vec[k[3:0]]) begin
                res.found = 1'b1;
                res.idx   = k[3:0];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter_if
//  Description : Requester/FIFO-side signal bundle for fifo_wr_arbiter.
//                'master' is the arbiter view, 'slave' the environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = c_def_num_req,
    parameter  int DATA_WIDTH = c_def_data_width,
    localparam int OWNER_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic                          busy;
    logic [OWNER_W-1:0]            owner;

    modport master (
        input  req, req_data, full,
        output gnt, w_en, data_in, busy, owner
    );

    modport slave (
        output req, req_data, full,
        input  gnt, w_en, data_in, busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick_onehot
//  Description : Combinational round-robin picker. Rotates the request
//                vector so the search starts one past 'i_last', isolates the
//                lowest set bit, and rotates back to a one-hot grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_onehot #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  wire logic [N-1:0] i_req,
    input  wire logic [W-1:0] i_last,
    output logic      [N-1:0] o_onehot,
    output logic      [W-1:0] o_idx,
    output logic              o_found
);
    logic [W-1:0] w_start;
    logic [N-1:0] w_rot;
    logic [N-1:0] w_pe;

    // Search origin is last+1, wrapped explicitly for non-power-of-2 N.
    assign w_start = (i_last == W'(N - 1)) ? '0 : i_last + W'(1);

    // Rotate so that bit 0 of w_rot is requester w_start.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = i_req[W'((i + int'(w_start)) % N)];
        end
    end

    // Lowest set bit of the rotated vector is the winner.
    assign w_pe = w_rot & (~w_rot + N'(1));

    // Undo the rotation to get the grant in requester numbering.
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < N; i++) begin
            o_onehot[W'((i + int'(w_start)) % N)] = w_pe[i];
        end
    end

    // Encode the one-hot winner into an index.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (o_onehot[i]) begin
                o_idx = o_idx | W'(i);
            end
        end
    end

    assign o_found = |i_req;
endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin write-port scheduler in front of async_fifo.
//                One arbitration cycle (IDLE) precedes each burst of up to
//                BURST_LEN beats; FIFO 'full' stalls the owner in place.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = c_def_num_req,
    parameter  int DATA_WIDTH = c_def_data_width,
    parameter  int BURST_LEN  = c_def_burst_len,
    localparam int OWNER_W    = $clog2(NUM_REQ)
) (
    input  wire logic          wclk,
    input  wire logic          wrst,
    fifo_wr_arbiter_if.master  bus
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [OWNER_W-1:0] r_owner;
    logic [OWNER_W-1:0] w_owner_nxt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               w_req_own;
    logic               w_beat;
    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [OWNER_W-1:0] w_pick_idx;
    logic               w_pick_found;

    rr_pick_onehot #(
        .N (NUM_REQ)
    ) u_pick (
        .i_req    (bus.req),
        .i_last   (r_owner),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_found  (w_pick_found)
    );

    // The one-hot view is for the read-side reuse of the picker.
    logic w_unused_onehot;
    assign w_unused_onehot = ^w_pick_onehot;

    assign w_req_own = bus.req[r_owner];
    assign w_beat    = (r_state == BURST) && w_req_own && !bus.full;

    // Reset gates the write strobe so a mid-burst reset never writes.
    assign bus.w_en    = w_beat && !wrst;
    assign bus.gnt     = NUM_REQ'(bus.w_en) << r_owner;
    assign bus.data_in = (r_state == BURST && !wrst)
                       ? bus.req_data[r_owner*DATA_WIDTH +: DATA_WIDTH]
                       : '0;
    assign bus.busy    = (r_state == BURST);
    assign bus.owner   = r_owner;

    // State, owner and beat counter registers.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state    <= IDLE;
            r_owner    <= OWNER_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, count beats and detect exit in BURST.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_owner_nxt = w_pick_idx;
                    w_cnt_nxt   = '0;
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                if (!w_req_own) begin
                    w_state_nxt = IDLE;
                end else if (w_beat) begin
                    w_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    if (r_beat_cnt == CNT_W'(BURST_LEN - 1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed self-checking bench for fifo_wr_arbiter
//                (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int BURST_LEN  = 4;

    logic wclk = 1'b0;
    logic wrst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   beats_seen [NUM_REQ];

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus.master)
    );

    always #5 wclk = ~wclk;

    // One clock: requesters advance their data on last cycle's grant, then
    // new inputs are applied just after the edge and outputs settle.
    task automatic tick(input logic [3:0] r, input logic f, input logic rs);
        for (int k = 0; k < NUM_REQ; k++)
            if (bus.gnt[k] === 1'b1) beats_seen[k]++;
        @(posedge wclk);
        #1;
        wrst     = rs;
        bus.req  = r;
        bus.full = f;
        for (int k = 0; k < NUM_REQ; k++)
            bus.req_data[k*DATA_WIDTH +: DATA_WIDTH] = 8'(8'h10 * k + beats_seen[k]);
        #1;
    endtask

    task automatic do_reset();
        tick(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < NUM_REQ; k++) beats_seen[k] = 0;
        tick(4'b0000, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        tick(4'b1111, 1'b0, 1'b1);
        tick(4'b1111, 1'b0, 1'b1);
        for (int k = 0; k < NUM_REQ; k++) beats_seen[k] = 0;
        total_cnt++; if (bus.w_en !== 1'b0) $display("FAIL reset_w_en: got %b want 0", bus.w_en); else pass_cnt++;
        total_cnt++; if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", bus.gnt); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.owner !== 2'd3) $display("FAIL reset_owner: got %0d want 3", bus.owner); else pass_cnt++;
        tick(4'b1111, 1'b0, 1'b0);
        total_cnt++; if (bus.w_en !== 1'b0) $display("FAIL reset_arb_w_en: got %b want 0", bus.w_en); else pass_cnt++;
        tick(4'b1111, 1'b0, 1'b0);
        total_cnt++; if (bus.owner !== 2'd0) $display("FAIL reset_first_owner: got %0d want 0", bus.owner); else pass_cnt++;
        total_cnt++; if (bus.gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b want 0001", bus.gnt); else pass_cnt++;
    endtask

    task automatic test_full_contention();
        logic [1:0] own;
        logic [7:0] exp_d;
        do_reset();
        tick(4'b1111, 1'b0, 1'b0);
        total_cnt++; if (bus.w_en !== 1'b0) $display("FAIL contend_arb_w_en: got %b want 0", bus.w_en); else pass_cnt++;
        for (int b = 0; b < 5; b++) begin
            own = 2'(b % 4);
            for (int j = 0; j < BURST_LEN; j++) begin
                tick(4'b1111, 1'b0, 1'b0);
                exp_d = 8'(8'h10 * int'(own) + 4 * (b / 4) + j);
                total_cnt++; if (bus.w_en !== 1'b1) $display("FAIL contend_w_en b%0d j%0d: got %b want 1", b, j, bus.w_en); else pass_cnt++;
                total_cnt++; if (bus.gnt !== (4'b0001 << own)) $display("FAIL contend_gnt b%0d j%0d: got %b want %b", b, j, bus.gnt, 4'b0001 << own); else pass_cnt++;
                total_cnt++; if (bus.data_in !== exp_d) $display("FAIL contend_data b%0d j%0d: got %h want %h", b, j, bus.data_in, exp_d); else pass_cnt++;
            end
            if (b < 4) begin
                tick(4'b1111, 1'b0, 1'b0);
                total_cnt++; if (bus.w_en !== 1'b0 || bus.busy !== 1'b0) $display("FAIL contend_gap b%0d: got w_en=%b busy=%b want 0/0", b, bus.w_en, bus.busy); else pass_cnt++;
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(4'b1111, 1'b0, 1'b0);
        repeat (12) tick(4'b1111, 1'b0, 1'b0);
        total_cnt++; if (bus.owner !== 2'd2 || bus.gnt !== 4'b0100) $display("FAIL stall_setup: got owner=%0d gnt=%b want 2/0100", bus.owner, bus.gnt); else pass_cnt++;
        for (int s = 0; s < 5; s++) begin
            tick(4'b1111, 1'b1, 1'b0);
            total_cnt++; if (bus.w_en !== 1'b0 || bus.gnt !== 4'b0000) $display("FAIL stall_write c%0d: got w_en=%b gnt=%b want 0/0000", s, bus.w_en, bus.gnt); else pass_cnt++;
            total_cnt++; if (bus.owner !== 2'd2 || bus.busy !== 1'b1) $display("FAIL stall_owner c%0d: got owner=%0d busy=%b want 2/1", s, bus.owner, bus.busy); else pass_cnt++;
        end
        tick(4'b1111, 1'b0, 1'b0);
        total_cnt++; if (bus.gnt !== 4'b0100 || bus.data_in !== 8'h22) $display("FAIL stall_resume1: got gnt=%b data=%h want 0100/22", bus.gnt, bus.data_in); else pass_cnt++;
        tick(4'b1111, 1'b0, 1'b0);
        total_cnt++; if (bus.gnt !== 4'b0100 || bus.data_in !== 8'h23) $display("FAIL stall_resume2: got gnt=%b data=%h want 0100/23", bus.gnt, bus.data_in); else pass_cnt++;
        tick(4'b1111, 1'b0, 1'b0);
        total_cnt++; if (bus.w_en !== 1'b0 || bus.busy !== 1'b0) $display("FAIL stall_end: got w_en=%b busy=%b want 0/0", bus.w_en, bus.busy); else pass_cnt++;
        tick(4'b1111, 1'b0, 1'b0);
        total_cnt++; if (bus.owner !== 2'd3 || bus.gnt !== 4'b1000) $display("FAIL stall_handover: got owner=%0d gnt=%b want 3/1000", bus.owner, bus.gnt); else pass_cnt++;
    endtask

    task automatic test_early_release();
        do_reset();
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        total_cnt++; if (bus.gnt !== 4'b0010 || bus.data_in !== 8'h10) $display("FAIL early_beat: got gnt=%b data=%h want 0010/10", bus.gnt, bus.data_in); else pass_cnt++;
        tick(4'b1000, 1'b0, 1'b0);
        total_cnt++; if (bus.w_en !== 1'b0 || bus.gnt !== 4'b0000) $display("FAIL early_drop_write: got w_en=%b gnt=%b want 0/0000", bus.w_en, bus.gnt); else pass_cnt++;
        tick(4'b1000, 1'b0, 1'b0);
        total_cnt++; if (bus.busy !== 1'b0 || bus.w_en !== 1'b0) $display("FAIL early_idle: got busy=%b w_en=%b want 0/0", bus.busy, bus.w_en); else pass_cnt++;
        tick(4'b1000, 1'b0, 1'b0);
        total_cnt++; if (bus.owner !== 2'd3 || bus.gnt !== 4'b1000 || bus.data_in !== 8'h30) $display("FAIL early_next: got owner=%0d gnt=%b data=%h want 3/1000/30", bus.owner, bus.gnt, bus.data_in); else pass_cnt++;
    endtask

    task automatic test_sparse();
        logic [3:0] r;
        int         nwr;
        nwr = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            r = (bus.gnt[2] === 1'b1) ? 4'b0000 : 4'b0100;
            tick(r, 1'b0, 1'b0);
            total_cnt++; if ((bus.gnt & 4'b1011) !== 4'b0000 || bus.gnt[2] !== bus.w_en) $display("FAIL sparse_gnt c%0d: got gnt=%b w_en=%b", i, bus.gnt, bus.w_en); else pass_cnt++;
            if (bus.w_en === 1'b1) begin
                total_cnt++; if (bus.data_in !== 8'(8'h20 + nwr)) $display("FAIL sparse_data w%0d: got %h want %h", nwr, bus.data_in, 8'(8'h20 + nwr)); else pass_cnt++;
                nwr++;
            end
        end
        total_cnt++; if (nwr !== 10) $display("FAIL sparse_count: got %0d want 10", nwr); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0010, 1'b0, 1'b0);
        total_cnt++; if (bus.gnt !== 4'b0010 || bus.data_in !== 8'h11) $display("FAIL rstmid_beat2: got gnt=%b data=%h want 0010/11", bus.gnt, bus.data_in); else pass_cnt++;
        tick(4'b0010, 1'b0, 1'b1);
        total_cnt++; if (bus.w_en !== 1'b0 || bus.gnt !== 4'b0000) $display("FAIL rstmid_suppress: got w_en=%b gnt=%b want 0/0000", bus.w_en, bus.gnt); else pass_cnt++;
        tick(4'b0011, 1'b0, 1'b0);
        total_cnt++; if (bus.busy !== 1'b0 || bus.owner !== 2'd3 || bus.w_en !== 1'b0) $display("FAIL rstmid_idle: got busy=%b owner=%0d w_en=%b want 0/3/0", bus.busy, bus.owner, bus.w_en); else pass_cnt++;
        tick(4'b0011, 1'b0, 1'b0);
        total_cnt++; if (bus.owner !== 2'd0 || bus.gnt !== 4'b0001 || bus.data_in !== 8'h00) $display("FAIL rstmid_regrant: got owner=%0d gnt=%b data=%h want 0/0001/00", bus.owner, bus.gnt, bus.data_in); else pass_cnt++;
    endtask

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.full     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) beats_seen[k] = 0;
        test_reset();
        test_full_contention();
        test_stall();
        test_early_release();
        test_sparse();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
